multicycle_adder_ctrl: RTL and testbench

MULTICYCLE_ADDER_CTRL -- requirements
Module: multicycle_adder_ctrl

---
 rtl/multicycle_adder_ctrl.sv | 142 ++++++++++++++
 tb/tb_multicycle_adder_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_adder_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_adder_ctrl: WIDTH-bit adder built from one reused 4-bit        |
// | carry-select slice, one nibble per cycle (IDLE -> ADD -> HOLD).           |
// | Optional macro OVERFLOW_FLAG_EN adds signed-overflow output V.            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module multicycle_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIn,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             Busy,
`ifdef OVERFLOW_FLAG_EN
  output logic             V,
`endif
  output logic             Done
);

  localparam int c_N  = WIDTH / 4;
  localparam int c_IW = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(c_N - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ADD  = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;
  logic             r_carry;
  logic [c_IW-1:0]  r_idx;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_s0;
  logic [3:0]       w_s1;
  logic             w_c0_out;
  logic             w_c1_out;
  logic             w_c0_msb;
  logic             w_c1_msb;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_slice_cmsb;

  // Two ripple chains with fixed carry-in 0 and 1; the carry register picks one.
  always_comb begin : g_slice
    logic [4:0] v_c0;
    logic [4:0] v_c1;
    w_a_nib = r_a[4*r_idx +: 4];
    w_b_nib = r_b[4*r_idx +: 4];
    v_c0    = 5'b00000;
    v_c1    = 5'b00001;
    w_s0    = 4'h0;
    w_s1    = 4'h0;
    for (int i = 0; i < 4; i++) begin
      w_s0[i]   = w_a_nib[i] ^ w_b_nib[i] ^ v_c0[i];
      v_c0[i+1] = (w_a_nib[i] & w_b_nib[i]) | (v_c0[i] & (w_a_nib[i] ^ w_b_nib[i]));
      w_s1[i]   = w_a_nib[i] ^ w_b_nib[i] ^ v_c1[i];
      v_c1[i+1] = (w_a_nib[i] & w_b_nib[i]) | (v_c1[i] & (w_a_nib[i] ^ w_b_nib[i]));
    end
    w_c0_out = v_c0[4];
    w_c1_out = v_c1[4];
    w_c0_msb = v_c0[3];
    w_c1_msb = v_c1[3];
  end

  assign w_slice_sum  = r_carry ? w_s1     : w_s0;
  assign w_slice_cout = r_carry ? w_c1_out : w_c0_out;
  assign w_slice_cmsb = r_carry ? w_c1_msb : w_c0_msb;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= c_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_co    <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (Run) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= CIn;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= c_ADD;
          end
        end
        c_ADD: begin
          r_sum[4*r_idx +: 4] <= w_slice_sum;
          r_carry             <= w_slice_cout;
          r_idx               <= r_idx + 1'b1;
          if (r_idx == c_LAST) begin
            r_co    <= w_slice_cout;
            r_state <= c_HOLD;
          end
        end
        c_HOLD: begin
          if (!Run) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic r_v;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_v <= 1'b0;
    end else if (r_state == c_ADD && r_idx == c_LAST) begin
      r_v <= w_slice_cmsb ^ w_slice_cout;
    end
  end

  assign V = r_v;
`else
  logic w_unused;
  assign w_unused = w_slice_cmsb;
`endif

  assign Sum  = r_sum;
  assign CO   = r_co;
  assign Busy = (r_state == c_ADD);
  assign Done = (r_state == c_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_adder_ctrl.sv
`default_nettype none
// Scoreboard bench for multicycle_adder_ctrl: a driver queues expected results
// from an arithmetic model and a monitor checks them on each Done rising edge.
module tb_multicycle_adder_ctrl;
  localparam int W = 16;
  localparam int N = W / 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Run = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CIn = 1'b0;
  logic [W-1:0] Sum;
  logic         CO;
  logic         Busy;
  logic         Done;
`ifdef OVERFLOW_FLAG_EN
  logic         V;
`endif

  multicycle_adder_ctrl #(.WIDTH(W)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Run  (Run),
    .A    (A),
    .B    (B),
    .CIn  (CIn),
    .Sum  (Sum),
    .CO   (CO),
    .Busy (Busy),
`ifdef OVERFLOW_FLAG_EN
    .V    (V),
`endif
    .Done (Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         v;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t      e;
    logic [W:0] t;
    int        s;
    t     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    s     = int'($signed(a)) + int'($signed(b)) + int'(ci);
    e.sum = t[W-1:0];
    e.co  = t[W];
    e.v   = (s > 32767) || (s < -32768);
    return e;
  endfunction

  always @(negedge Clk) begin
    if (Done && !prev_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", 32'(Sum), 32'(e.sum));
        chk("co", 32'(CO), 32'(e.co));
`ifdef OVERFLOW_FLAG_EN
        chk("v", 32'(V), 32'(e.v));
`endif
      end
    end
    prev_done = Done;
  end

  // mode 0: Run dropped after start; 1: random input noise during ADD;
  // 2: operands zeroed and Run toggled on cycle 2 of ADD.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input int mode, input int hold);
    int cyc;
    int busy_n;
    @(negedge Clk);
    A = a; B = b; CIn = ci; Run = 1'b1;
    exp_q.push_back(model(a, b, ci));
    @(posedge Clk);
    cyc = 0;
    busy_n = 0;
    forever begin
      @(negedge Clk);
      if (Done || cyc > 20) break;
      if (Busy) busy_n++;
      cyc++;
      if (mode == 1) begin
        A = W'($urandom); B = W'($urandom); CIn = 1'($urandom); Run = 1'($urandom);
      end else if (mode == 2 && cyc == 2) begin
        A = '0; B = '0; Run = ~Run;
      end else if (mode == 0) begin
        Run = 1'b0;
      end
    end
    chk("latency", 32'(cyc), 32'(N));
    chk("busy_cycles", 32'(busy_n), 32'(N));
    Run = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      chk("hold_done", 32'(Done), 32'd1);
    end
    Run = 1'b0;
    @(negedge Clk);
    chk("idle_done", 32'(Done), 32'd0);
    chk("idle_busy", 32'(Busy), 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_co", 32'(CO), 32'd0);

    do_op(16'h1234, 16'h4321, 1'b0, 0, 0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 0, 2);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1, 0);
    do_op(16'hAAAA, 16'h5555, 1'b0, 2, 0);

    // Abort mid-ADD: nothing queued, state and result must clear.
    @(negedge Clk);
    A = 16'hFFFF; B = 16'hFFFF; CIn = 1'b1; Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_sum", 32'(Sum), 32'd0);
    chk("abort_co", 32'(CO), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    chk("abort_v", 32'(V), 32'd0);
`endif
    @(negedge Clk);
    Reset = 1'b0;
    do_op(16'h0001, 16'h0001, 1'b0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)));
    end

    do_op(16'h8000, 16'h8000, 1'b0, 0, 10);

    repeat (3) @(negedge Clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
